// File: rtl/downstream_vc_tracker.sv
// Upstream mirror of every downstream input VC: allocation state and credit count per VC.
// Optional sticky protocol checker enabled by defining DOWNSTREAM_VC_TRACKER_CHECK_EN.
module downstream_vc_tracker #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int VC_TOTAL    = PORT_NUM * VC_NUM,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VC_TOTAL-1:0] vc_allocated_i,
  input  logic [VC_TOTAL-1:0] flit_sent_i,
  input  logic [VC_TOTAL-1:0] tail_sent_i,
  input  logic [VC_TOTAL-1:0] credit_i,
  output logic [VC_TOTAL-1:0] idle_downstream_vc_o,
  output logic [VC_TOTAL-1:0] credit_available_o,
  output logic                error_o
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [VC_TOTAL-1:0][1:0]    r_state;
  logic [VC_TOTAL-1:0][CW-1:0] r_count;
  logic [VC_TOTAL-1:0][1:0]    w_state_nxt;
  logic [VC_TOTAL-1:0][CW-1:0] w_count_nxt;
  logic [VC_TOTAL-1:0]         w_flit_ok;
  logic [VC_TOTAL-1:0]         w_dec;
  logic [VC_TOTAL-1:0]         w_inc;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_flit_ok   = '0;
    w_dec       = '0;
    w_inc       = '0;
    for (int v = 0; v < VC_TOTAL; v++) begin
      // Flits only count while the VC is owned; credits are accepted in any state.
      w_flit_ok[v]   = flit_sent_i[v] && (r_state[v] == S_ACTIVE);
      w_dec[v]       = w_flit_ok[v] && (r_count[v] != '0);
      w_inc[v]       = credit_i[v] && (r_count[v] != FULL);
      w_count_nxt[v] = r_count[v] + CW'(w_inc[v]) - CW'(w_dec[v]);
      case (r_state[v])
        S_IDLE:   if (vc_allocated_i[v]) w_state_nxt[v] = S_ACTIVE;
        S_ACTIVE: if (w_flit_ok[v] && tail_sent_i[v]) w_state_nxt[v] = S_DRAIN;
        S_DRAIN:  if (w_count_nxt[v] == FULL) w_state_nxt[v] = S_IDLE;
        default:  w_state_nxt[v] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= {VC_TOTAL{S_IDLE}};
      r_count <= {VC_TOTAL{FULL}};
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    idle_downstream_vc_o = '0;
    credit_available_o   = '0;
    for (int v = 0; v < VC_TOTAL; v++) begin
      idle_downstream_vc_o[v] = (r_state[v] == S_IDLE);
      credit_available_o[v]   = (r_count[v] != '0);
    end
  end

`ifdef DOWNSTREAM_VC_TRACKER_CHECK_EN
  logic w_err_evt;
  logic r_error;

  always_comb begin
    w_err_evt = 1'b0;
    for (int v = 0; v < VC_TOTAL; v++) begin
      if (flit_sent_i[v] && (r_count[v] == '0))          w_err_evt = 1'b1;
      if (credit_i[v] && (r_count[v] == FULL))           w_err_evt = 1'b1;
      if (vc_allocated_i[v] && (r_state[v] != S_IDLE))   w_err_evt = 1'b1;
      if (flit_sent_i[v] && (r_state[v] != S_ACTIVE))    w_err_evt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_error <= 1'b0;
    else if (w_err_evt) r_error <= 1'b1;
  end

  assign error_o = r_error;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_downstream_vc_tracker.sv
// Directed bench for downstream_vc_tracker: vector table plus hand sequences for reset and all-VC cases.
module tb_downstream_vc_tracker;

  localparam int VT = 10;
`ifdef DOWNSTREAM_VC_TRACKER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [VT-1:0] vc_allocated_i;
  logic [VT-1:0] flit_sent_i;
  logic [VT-1:0] tail_sent_i;
  logic [VT-1:0] credit_i;
  logic [VT-1:0] idle_downstream_vc_o;
  logic [VT-1:0] credit_available_o;
  logic          error_o;

  int checks = 0;
  int errors = 0;

  downstream_vc_tracker dut (
    .clk                  (clk),
    .rst                  (rst),
    .vc_allocated_i       (vc_allocated_i),
    .flit_sent_i          (flit_sent_i),
    .tail_sent_i          (tail_sent_i),
    .credit_i             (credit_i),
    .idle_downstream_vc_o (idle_downstream_vc_o),
    .credit_available_o   (credit_available_o),
    .error_o              (error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [VT-1:0] alloc;
    logic [VT-1:0] flit;
    logic [VT-1:0] tail;
    logic [VT-1:0] credit;
    logic [VT-1:0] exp_idle;
    logic [VT-1:0] exp_cav;
    logic          exp_err;  // expected error_o when the checker is built in
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic [VT-1:0] a, logic [VT-1:0] f, logic [VT-1:0] t,
                              logic [VT-1:0] c, logic [VT-1:0] ei, logic [VT-1:0] ec, logic ee);
    vec_t v;
    v.name = n; v.alloc = a; v.flit = f; v.tail = t; v.credit = c;
    v.exp_idle = ei; v.exp_cav = ec; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic check_out(string n, logic [VT-1:0] ei, logic [VT-1:0] ec, logic ee);
    logic exp_e;
    exp_e = ee & CHK;
    checks++;
    if (idle_downstream_vc_o !== ei) begin
      errors++;
      $display("FAIL %s idle: got %h expected %h", n, idle_downstream_vc_o, ei);
    end
    checks++;
    if (credit_available_o !== ec) begin
      errors++;
      $display("FAIL %s credit_available: got %h expected %h", n, credit_available_o, ec);
    end
    checks++;
    if (error_o !== exp_e) begin
      errors++;
      $display("FAIL %s error: got %b expected %b", n, error_o, exp_e);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge, then release inputs.
  task automatic step(logic [VT-1:0] a, logic [VT-1:0] f, logic [VT-1:0] t, logic [VT-1:0] c);
    @(negedge clk);
    vc_allocated_i = a; flit_sent_i = f; tail_sent_i = t; credit_i = c;
    @(posedge clk);
    #1;
    vc_allocated_i = '0; flit_sent_i = '0; tail_sent_i = '0; credit_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("reset_async", 10'h3FF, 10'h3FF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    vc_allocated_i = '0; flit_sent_i = '0; tail_sent_i = '0; credit_i = '0;

    for (int i = 0; i < 5; i++) add("reset_idle", '0, '0, '0, '0, 10'h3FF, 10'h3FF, 1'b0);
    add("alloc3", 10'h008, '0, '0, '0, 10'h3F7, 10'h3FF, 1'b0);
    for (int i = 1; i <= 8; i++)
      add("flit3", '0, 10'h008, '0, '0, 10'h3F7, (i == 8) ? 10'h3F7 : 10'h3FF, 1'b0);
    add("flit3_at_zero", '0, 10'h008, '0, '0, 10'h3F7, 10'h3F7, 1'b1);
    add("credit3", '0, '0, '0, 10'h008, 10'h3F7, 10'h3FF, 1'b1);
    add("tail3", '0, 10'h008, 10'h008, '0, 10'h3F7, 10'h3F7, 1'b1);
    for (int i = 1; i <= 8; i++)
      add("drain_credit3", '0, '0, '0, 10'h008, (i == 8) ? 10'h3FF : 10'h3F7, 10'h3FF, 1'b1);
    add("alloc5", 10'h020, '0, '0, '0, 10'h3DF, 10'h3FF, 1'b1);
    for (int i = 1; i <= 4; i++) add("flit5", '0, 10'h020, '0, '0, 10'h3DF, 10'h3FF, 1'b1);
    add("flit_credit5", '0, 10'h020, '0, 10'h020, 10'h3DF, 10'h3FF, 1'b1);
    add("tail_only5", '0, '0, 10'h020, '0, 10'h3DF, 10'h3FF, 1'b1);
    for (int i = 1; i <= 4; i++)
      add("flit5_to_zero", '0, 10'h020, '0, '0, 10'h3DF, (i == 4) ? 10'h3DF : 10'h3FF, 1'b1);
    add("tail5_at_zero", '0, 10'h020, 10'h020, '0, 10'h3DF, 10'h3DF, 1'b1);
    for (int i = 1; i <= 8; i++)
      add("drain_credit5", '0, '0, '0, 10'h020, (i == 8) ? 10'h3FF : 10'h3DF, 10'h3FF, 1'b1);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].alloc, vecs[i].flit, vecs[i].tail, vecs[i].credit);
      check_out(vecs[i].name, vecs[i].exp_idle, vecs[i].exp_cav, vecs[i].exp_err);
    end

    // All VCs carry a single-flit packet; only even VCs get their credit back.
    do_reset();
    step(10'h3FF, '0, '0, '0);
    check_out("alloc_all", 10'h000, 10'h3FF, 1'b0);
    step('0, 10'h3FF, 10'h3FF, '0);
    check_out("headtail_all", 10'h000, 10'h3FF, 1'b0);
    step('0, '0, '0, 10'h155);
    check_out("credit_even", 10'h155, 10'h3FF, 1'b0);
    step(10'h002, '0, '0, '0);
    check_out("realloc_drain1", 10'h155, 10'h3FF, 1'b1);

    // Flit on an idle VC is ignored but is a protocol error.
    do_reset();
    step('0, 10'h004, 10'h004, '0);
    check_out("flit_idle2", 10'h3FF, 10'h3FF, 1'b1);

    // Reset in the middle of a packet on VC7, then late credits.
    do_reset();
    step(10'h080, '0, '0, '0);
    check_out("alloc7", 10'h37F, 10'h3FF, 1'b0);
    for (int i = 0; i < 6; i++) step('0, 10'h080, '0, '0);
    check_out("vc7_count2", 10'h37F, 10'h3FF, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_out("reset_mid_packet", 10'h3FF, 10'h3FF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step('0, '0, '0, 10'h080);
    check_out("late_credits7", 10'h3FF, 10'h3FF, 1'b1);
    step(10'h080, '0, '0, '0);
    for (int i = 1; i <= 8; i++) begin
      step('0, 10'h080, '0, '0);
      check_out("vc7_saturated", 10'h37F, (i == 8) ? 10'h37F : 10'h3FF, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
